// File: rtl/aibcr3aux_osc_pkg.sv
// Shared types and helpers for the aux-oscillator scannable counter.
// Mode encoding and the load clamp used by the counter next-state logic.
package aibcr3aux_osc_pkg;

   localparam int MAX_W = 32;

   typedef enum logic [2:0] {
      M_RST,
      M_SCAN,
      M_LOAD,
      M_CNT,
      M_HOLD
   } mode_e;

   // Operands are zero-extended to MAX_W bits by the caller.
   function automatic logic [MAX_W-1:0] clamp_max(
      input logic [MAX_W-1:0] val,
      input logic [MAX_W-1:0] max_val
   );
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/aibcr3aux_osc_scan_bit.sv
// One mux-D scan flop with synchronous active-high reset.
// Reset wins over scan, and scan wins over functional data.
module aibcr3aux_osc_scan_bit (
   input  logic cp,
   input  logic rst,
   input  logic se_n,
   input  logic si,
   input  logic d,
   output logic q
);

   always_ff @(posedge cp) begin
      if (rst)
         q <= 1'b0;
      else if (!se_n)
         q <= si;
      else
         q <= d;
   end

endmodule

// File: rtl/aibcr3aux_osc_scan_cnt.sv
// Scannable WIDTH-bit osc-cycle counter with load, wrap/saturate and sticky overflow.
// Scan chain runs si -> q[0] .. q[WIDTH-1] -> ovf -> so.
module aibcr3aux_osc_scan_cnt
   import aibcr3aux_osc_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter bit               SAT_MODE = 1'b0
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             se_n,
   input  logic             si,
   output logic             so,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   if (WIDTH < 2) begin : g_bad_width
      $error("aibcr3aux_osc_scan_cnt: WIDTH must be >= 2");
   end

   if (WIDTH > MAX_W) begin : g_wide
      $error("aibcr3aux_osc_scan_cnt: WIDTH exceeds clamp width");
   end

   if (MAX_VAL == '0) begin : g_bad_max
      $error("aibcr3aux_osc_scan_cnt: MAX_VAL must be > 0");
   end

   mode_e            mode;
   logic [WIDTH:0]   chain_q;
   logic [WIDTH:0]   chain_d;
   logic [WIDTH:0]   chain_si;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] ld_clamped;
   logic             ovf_d;
   logic             tc_d;
   logic             at_max;

   assign q   = chain_q[WIDTH-1:0];
   assign ovf = chain_q[WIDTH];
   assign so  = chain_q[WIDTH];

   assign at_max     = (q == MAX_VAL);
   assign ld_clamped = WIDTH'(clamp_max(MAX_W'(ld_val),
                                        MAX_W'(MAX_VAL)));

   always_comb begin
      if (rst)
         mode = M_RST;
      else if (!se_n)
         mode = M_SCAN;
      else if (ld)
         mode = M_LOAD;
      else if (en)
         mode = M_CNT;
      else
         mode = M_HOLD;
   end

   always_comb begin
      q_d   = q;
      ovf_d = ovf;
      tc_d  = 1'b0;
      unique case (mode)
         M_LOAD: begin
            q_d   = ld_clamped;
            ovf_d = 1'b0;
         end
         M_CNT: begin
            if (at_max) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
               q_d   = SAT_MODE ? MAX_VAL : '0;
            end else begin
               q_d = q + WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   assign chain_d  = {ovf_d, q_d};
   assign chain_si = {chain_q[WIDTH-1:0], si};

   for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
      aibcr3aux_osc_scan_bit u_bit (
         .cp   (cp),
         .rst  (rst),
         .se_n (se_n),
         .si   (chain_si[i]),
         .d    (chain_d[i]),
         .q    (chain_q[i])
      );
   end

   // tc is not part of the chain; it is simply held low while shifting.
   always_ff @(posedge cp) begin
      if (rst)
         tc <= 1'b0;
      else
         tc <= tc_d;
   end

endmodule
